rtc_field_editor: RTL and testbench

- Consumes the debounced pulses and levels from the button/switch debouncer and turns them into editable RTC time/date/timer fields.
- Outputs the fields in BCD with a cursor index, and hands a completed edit to the RTC write controller via a req/ack handshake.
- Sits between the debouncer and the RTC bus-write FSM.

---
 rtl/rtc_field_editor.sv | 237 +++++++++++++++++++++++
 tb/tb_rtc_field_editor.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_field_editor.sv
// Field editor that turns debounced button pulses into BCD RTC fields and a write handshake.
// Optional macro RTC_EDIT_PRELOAD_EN adds rd_* inputs that preload the fields on entry to EDIT.
module rtc_field_editor #(
  parameter int unsigned ACK_TIMEOUT = 1000000
) (
  input  logic       clk,
  input  logic       btn_reset,
  input  logic       dism,
  input  logic       aument,
  input  logic       derec,
  input  logic       izqda,
  input  logic       escrib,
  input  logic       sw_conf,
  input  logic       sw_CT,
  input  logic       DOCE_24,
  input  logic       wr_ack,
`ifdef RTC_EDIT_PRELOAD_EN
  input  logic [7:0] rd_seg,
  input  logic [7:0] rd_min,
  input  logic [7:0] rd_hr,
  input  logic [7:0] rd_day,
  input  logic [7:0] rd_mon,
  input  logic [7:0] rd_yr,
`endif
  output logic [7:0] seg_bcd,
  output logic [7:0] min_bcd,
  output logic [7:0] hr_bcd,
  output logic [7:0] day_bcd,
  output logic [7:0] mon_bcd,
  output logic [7:0] yr_bcd,
  output logic [2:0] cursor,
  output logic       wr_req,
  output logic       wr_target,
  output logic       editing,
  output logic       err
);

  localparam int unsigned CntW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StEdit, StReq} state_e;

  state_e state_q, state_d;
  logic [7:0] sec_q, sec_d, min_q, min_d, hr_q, hr_d;
  logic [7:0] day_q, day_d, mon_q, mon_d, yr_q, yr_d;
  logic [2:0] cursor_q, cursor_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic fmt_q, fmt_d, escrib_q, wr_target_q, wr_target_d, err_q, err_d;
  logic editing_q, wr_req_q;
  logic up, dn;
  logic [2:0] cur_max;

  function automatic logic [6:0] bcd2bin(input logic [7:0] b);
    return {3'b0, b[7:4]} * 7'd10 + {3'b0, b[3:0]};
  endfunction

  function automatic logic [7:0] bin2bcd(input logic [6:0] v);
    logic [6:0] t, o;
    t = v / 7'd10;
    o = v - t * 7'd10;
    return {t[3:0], o[3:0]};
  endfunction

  function automatic logic [6:0] step(input logic [6:0] v, input logic [6:0] lo,
                                      input logic [6:0] hi, input logic inc);
    if (inc) return (v >= hi) ? lo : v + 7'd1;
    else     return (v <= lo) ? hi : v - 7'd1;
  endfunction

  // In 12h mode the PM bit flips only across the 11<->12 boundary.
  function automatic logic [7:0] hr_step(input logic [7:0] h, input logic twelve,
                                         input logic inc);
    logic [6:0] v;
    logic [7:0] b;
    logic pm;
    v  = bcd2bin({1'b0, h[6:0]});
    pm = h[7];
    if (!twelve) return bin2bcd(step(v, 7'd0, 7'd23, inc));
    if (inc) begin
      if (v == 7'd11) pm = ~pm;
      v = (v >= 7'd12) ? 7'd1 : v + 7'd1;
    end else begin
      if (v == 7'd12) pm = ~pm;
      v = (v <= 7'd1) ? 7'd12 : v - 7'd1;
    end
    b = bin2bcd(v);
    return {pm, b[6:0]};
  endfunction

  function automatic logic [7:0] hr_convert(input logic [7:0] h, input logic to_twelve);
    logic [6:0] v;
    logic [7:0] b;
    logic pm;
    v  = bcd2bin({1'b0, h[6:0]});
    pm = h[7];
    if (to_twelve) begin
      pm = (v >= 7'd12);
      if (v == 7'd0)       v = 7'd12;
      else if (v > 7'd12)  v = v - 7'd12;
      b = bin2bcd(v);
      return {pm, b[6:0]};
    end
    if (v == 7'd12) v = pm ? 7'd12 : 7'd0;
    else if (pm)    v = v + 7'd12;
    return bin2bcd(v);
  endfunction

  always_comb begin
    state_d     = state_q;
    sec_d       = sec_q;
    min_d       = min_q;
    hr_d        = hr_q;
    day_d       = day_q;
    mon_d       = mon_q;
    yr_d        = yr_q;
    cursor_d    = cursor_q;
    cnt_d       = cnt_q;
    fmt_d       = fmt_q;
    wr_target_d = wr_target_q;
    err_d       = err_q;
    up          = aument & ~dism;
    dn          = dism & ~aument;
    cur_max     = sw_CT ? 3'd2 : 3'd5;

    unique case (state_q)
      StIdle: if (sw_conf) state_d = StEdit;
      StEdit: begin
        if (!sw_conf) begin
          state_d = StIdle;
        end else if (escrib && !escrib_q) begin
          state_d     = StReq;
          wr_target_d = sw_CT;
          err_d       = 1'b0;
          cnt_d       = '0;
        end
      end
      StReq: begin
        if (wr_ack) begin
          state_d = StEdit;
        end else if (cnt_q == CntMax) begin
          state_d = StEdit;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (state_q == StEdit) begin
      if (up || dn) begin
        case (cursor_q)
          3'd0: sec_d = bin2bcd(step(bcd2bin(sec_q), 7'd0, 7'd59, up));
          3'd1: min_d = bin2bcd(step(bcd2bin(min_q), 7'd0, 7'd59, up));
          3'd2: hr_d  = hr_step(hr_q, fmt_q, up);
          3'd3: day_d = bin2bcd(step(bcd2bin(day_q), 7'd1, 7'd31, up));
          3'd4: mon_d = bin2bcd(step(bcd2bin(mon_q), 7'd1, 7'd12, up));
          3'd5: yr_d  = bin2bcd(step(bcd2bin(yr_q), 7'd0, 7'd99, up));
          default: ;
        endcase
      end
      if (derec && !izqda) cursor_d = (cursor_q >= cur_max) ? 3'd0 : cursor_q + 3'd1;
      if (izqda && !derec) begin
        cursor_d = (cursor_q == 3'd0 || cursor_q > cur_max) ? cur_max : cursor_q - 3'd1;
      end
    end

    if (sw_CT && cursor_q > 3'd2) cursor_d = 3'd0;

    // Hour is re-encoded once the format flips; a pending write keeps its snapshot.
    if (state_q != StReq && DOCE_24 != fmt_q) begin
      hr_d  = hr_convert(hr_q, DOCE_24);
      fmt_d = DOCE_24;
    end

`ifdef RTC_EDIT_PRELOAD_EN
    if (state_q == StIdle && state_d == StEdit) begin
      sec_d    = rd_seg;
      min_d    = rd_min;
      hr_d     = rd_hr;
      day_d    = rd_day;
      mon_d    = rd_mon;
      yr_d     = rd_yr;
      cursor_d = 3'd0;
    end
`endif
  end

  always_ff @(posedge clk or posedge btn_reset) begin
    if (btn_reset) begin
      state_q     <= StIdle;
      sec_q       <= 8'h00;
      min_q       <= 8'h00;
      hr_q        <= 8'h00;
      day_q       <= 8'h01;
      mon_q       <= 8'h01;
      yr_q        <= 8'h00;
      cursor_q    <= 3'd0;
      cnt_q       <= '0;
      fmt_q       <= 1'b0;
      escrib_q    <= 1'b0;
      wr_target_q <= 1'b0;
      err_q       <= 1'b0;
      editing_q   <= 1'b0;
      wr_req_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sec_q       <= sec_d;
      min_q       <= min_d;
      hr_q        <= hr_d;
      day_q       <= day_d;
      mon_q       <= mon_d;
      yr_q        <= yr_d;
      cursor_q    <= cursor_d;
      cnt_q       <= cnt_d;
      fmt_q       <= fmt_d;
      escrib_q    <= escrib;
      wr_target_q <= wr_target_d;
      err_q       <= err_d;
      editing_q   <= (state_d == StEdit);
      wr_req_q    <= (state_d == StReq);
    end
  end

  assign seg_bcd   = sec_q;
  assign min_bcd   = min_q;
  assign hr_bcd    = hr_q;
  assign day_bcd   = day_q;
  assign mon_bcd   = mon_q;
  assign yr_bcd    = yr_q;
  assign cursor    = cursor_q;
  assign wr_req    = wr_req_q;
  assign wr_target = wr_target_q;
  assign editing   = editing_q;
  assign err       = err_q;

endmodule

// File: tb/tb_rtc_field_editor.sv
// Scoreboard bench for rtc_field_editor: stimulus queues expected values, a negedge monitor checks.
module tb_rtc_field_editor;

  logic clk = 1'b0;
  logic btn_reset, dism, aument, derec, izqda, escrib, sw_conf, sw_CT, DOCE_24, wr_ack;
  logic [7:0] seg_bcd, min_bcd, hr_bcd, day_bcd, mon_bcd, yr_bcd;
  logic [2:0] cursor;
  logic wr_req, wr_target, editing, err;

  rtc_field_editor #(.ACK_TIMEOUT(8)) dut (
    .clk       (clk),
    .btn_reset (btn_reset),
    .dism      (dism),
    .aument    (aument),
    .derec     (derec),
    .izqda     (izqda),
    .escrib    (escrib),
    .sw_conf   (sw_conf),
    .sw_CT     (sw_CT),
    .DOCE_24   (DOCE_24),
    .wr_ack    (wr_ack),
    .seg_bcd   (seg_bcd),
    .min_bcd   (min_bcd),
    .hr_bcd    (hr_bcd),
    .day_bcd   (day_bcd),
    .mon_bcd   (mon_bcd),
    .yr_bcd    (yr_bcd),
    .cursor    (cursor),
    .wr_req    (wr_req),
    .wr_target (wr_target),
    .editing   (editing),
    .err       (err)
  );

  always #5 clk = ~clk;

  localparam int SEC = 0, MIN = 1, HR = 2, DAY = 3, MON = 4, YR = 5;
  localparam int CUR = 6, REQ = 7, TGT = 8, EDT = 9, ERR = 10;
  localparam logic [3:0] AU = 4'b0001, DI = 4'b0010, DR = 4'b0100, IZ = 4'b1000;

  string      q_name[$];
  int         q_sel[$];
  logic [7:0] q_exp[$];
  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [7:0] observe(input int sel);
    case (sel)
      SEC: return seg_bcd;
      MIN: return min_bcd;
      HR:  return hr_bcd;
      DAY: return day_bcd;
      MON: return mon_bcd;
      YR:  return yr_bcd;
      CUR: return {5'b0, cursor};
      REQ: return {7'b0, wr_req};
      TGT: return {7'b0, wr_target};
      EDT: return {7'b0, editing};
      default: return {7'b0, err};
    endcase
  endfunction

  task automatic expect_v(input string n, input int sel, input logic [7:0] v);
    q_name.push_back(n);
    q_sel.push_back(sel);
    q_exp.push_back(v);
  endtask

  always @(negedge clk) begin
    while (q_sel.size() > 0) begin : mon_pop
      string n;
      int s;
      logic [7:0] e, a;
      n = q_name.pop_front();
      s = q_sel.pop_front();
      e = q_exp.pop_front();
      a = observe(s);
      n_checks++;
      if (a !== e) begin
        n_fail++;
        $display("FAIL %s: got %h, want %h", n, a, e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] m);
    {izqda, derec, dism, aument} = m;
    tick();
    {izqda, derec, dism, aument} = 4'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "timeout");
  end

  initial begin
    btn_reset = 1'b1;
    {dism, aument, derec, izqda, escrib, sw_conf, sw_CT, DOCE_24, wr_ack} = '0;
    repeat (2) @(posedge clk);
    #1 btn_reset = 1'b0;
    expect_v("rst_sec", SEC, 8'h00); expect_v("rst_min", MIN, 8'h00);
    expect_v("rst_hr", HR, 8'h00);   expect_v("rst_day", DAY, 8'h01);
    expect_v("rst_mon", MON, 8'h01); expect_v("rst_yr", YR, 8'h00);
    expect_v("rst_cur", CUR, 8'h00); expect_v("rst_req", REQ, 8'h00);
    expect_v("rst_tgt", TGT, 8'h00); expect_v("rst_edit", EDT, 8'h00);
    expect_v("rst_err", ERR, 8'h00);
    tick();

    // Edit seconds, then confirm IDLE ignores pulses
    sw_conf = 1'b1; tick();
    expect_v("enter_edit", EDT, 8'h01);
    repeat (3) pulse(AU);
    expect_v("sec_inc3", SEC, 8'h03);
    sw_conf = 1'b0; tick();
    expect_v("leave_edit", EDT, 8'h00);
    repeat (2) pulse(AU);
    expect_v("idle_ignores", SEC, 8'h03);

    // Wraps on min, yr, day, mon and simultaneous pulses
    sw_conf = 1'b1; tick();
    pulse(DR);                 expect_v("cur_r1", CUR, 8'h01);
    pulse(DI);                 expect_v("min_wrap", MIN, 8'h59);
    repeat (4) pulse(DR);      expect_v("cur_r5", CUR, 8'h05);
    pulse(DI);                 expect_v("yr_dn_wrap", YR, 8'h99);
    pulse(AU);                 expect_v("yr_up_wrap", YR, 8'h00);
    pulse(AU | DI);            expect_v("au_di_hold", YR, 8'h00);
    pulse(DR | IZ);            expect_v("dr_iz_hold", CUR, 8'h05);
    repeat (2) pulse(IZ);      expect_v("cur_l3", CUR, 8'h03);
    pulse(DI);                 expect_v("day_dn_wrap", DAY, 8'h31);
    pulse(AU);                 expect_v("day_up_wrap", DAY, 8'h01);
    pulse(DR);                 expect_v("cur_r4", CUR, 8'h04);
    pulse(DI);                 expect_v("mon_dn_wrap", MON, 8'h12);
    pulse(DR);
    pulse(AU | DR);
    expect_v("val_old_cur", YR, 8'h01);
    expect_v("cur_wrap_r", CUR, 8'h00);

    // Cursor range follows sw_CT
    pulse(IZ);                 expect_v("cur_wrap_l5", CUR, 8'h05);
    sw_CT = 1'b1; tick();      expect_v("cur_force0", CUR, 8'h00);
    pulse(IZ);                 expect_v("cur_wrap_l2", CUR, 8'h02);
    pulse(IZ);                 expect_v("cur_l1", CUR, 8'h01);

    // Hour editing and 12/24h conversion
    pulse(DR);                 expect_v("cur_hr", CUR, 8'h02);
    pulse(DI);                 expect_v("hr24_wrap", HR, 8'h23);
    DOCE_24 = 1'b1; tick(); tick();
    expect_v("hr_to12", HR, 8'h91);
    pulse(AU);                 expect_v("hr_11p_12a", HR, 8'h12);
    pulse(DI);                 expect_v("hr_12a_11p", HR, 8'h91);
    pulse(AU);                 expect_v("hr_back_12a", HR, 8'h12);
    pulse(AU);                 expect_v("hr_12_01", HR, 8'h01);
    pulse(DI);                 expect_v("hr_01_12", HR, 8'h12);
    DOCE_24 = 1'b0; tick(); tick();
    expect_v("hr_to24", HR, 8'h00);

    // Write handshake with ack; sw_conf drop deferred
    escrib = 1'b1; tick();
    expect_v("req_up", REQ, 8'h01);
    expect_v("req_tgt", TGT, 8'h01);
    expect_v("req_noedit", EDT, 8'h00);
    repeat (2) pulse(AU);
    expect_v("req_frozen_hr", HR, 8'h00);
    expect_v("req_frozen_sec", SEC, 8'h03);
    sw_conf = 1'b0; tick();
    expect_v("req_hold_conf", REQ, 8'h01);
    wr_ack = 1'b1; tick(); wr_ack = 1'b0;
    expect_v("ack_drop", REQ, 8'h00);
    expect_v("ack_edit", EDT, 8'h01);
    expect_v("ack_hr", HR, 8'h00);
    expect_v("ack_err", ERR, 8'h00);
    tick();
    expect_v("post_ack_idle", EDT, 8'h00);
    escrib = 1'b0; sw_conf = 1'b1; tick();
    expect_v("reenter_edit", EDT, 8'h01);

    // Timeout path, err set then cleared by next request
    sw_CT = 1'b0; escrib = 1'b1; tick();
    expect_v("to_req_up", REQ, 8'h01);
    expect_v("to_tgt", TGT, 8'h00);
    repeat (7) tick();
    expect_v("to_req_7", REQ, 8'h01);
    expect_v("to_err_7", ERR, 8'h00);
    tick();
    expect_v("to_req_8", REQ, 8'h00);
    expect_v("to_err_8", ERR, 8'h01);
    expect_v("to_edit", EDT, 8'h01);
    escrib = 1'b0; tick();
    escrib = 1'b1; tick();
    expect_v("err_clear", ERR, 8'h00);
    expect_v("req_again", REQ, 8'h01);
    tick(); tick();

    // Asynchronous reset in the middle of a request
    btn_reset = 1'b1;
    #1;
    expect_v("ar_req", REQ, 8'h00);  expect_v("ar_err", ERR, 8'h00);
    expect_v("ar_edit", EDT, 8'h00); expect_v("ar_cur", CUR, 8'h00);
    expect_v("ar_sec", SEC, 8'h00);  expect_v("ar_min", MIN, 8'h00);
    expect_v("ar_hr", HR, 8'h00);    expect_v("ar_day", DAY, 8'h01);
    expect_v("ar_mon", MON, 8'h01);  expect_v("ar_yr", YR, 8'h00);
    expect_v("ar_tgt", TGT, 8'h00);
    @(negedge clk);
    #1;
    if (q_sel.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending, want 0", q_sel.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
